// File: rtl/piso_serializer.sv
// Parallel-in / serial-out converter.
// Each accepted word goes out one bit per cycle, in the bit order set by
// MSB_FIRST. After each word the block waits GAP_CYCLES idle cycles before it
// accepts the next word.
// All outputs come from registers or from the decoded state. There is no
// combinational path from din_i or din_valid_i to any output.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for a word, din_ready_o high
//   ST_SHIFT | emitting WIDTH bits, one per cycle, sout_valid_o high
//   ST_GAP   | GAP_CYCLES quiet cycles after a word, line held low
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  output logic             sout_o,
  output logic             sout_valid_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  // The gap counter counts down to zero. It is loaded with GAP_CYCLES-1 so
  // that the block spends exactly GAP_CYCLES cycles in ST_GAP.
  localparam logic [3:0]       GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       gap_q,   gap_d;
  logic             sout_q,  sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             last_q,  last_d;
  logic [CNT_W-1:0] cnt_nxt;

  // Returns the bit that goes out next.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end
    return w[0];
  endfunction

  // Returns the word with the bit just sent removed.
  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w << 1;
    end
    return w >> 1;
  endfunction

  assign cnt_nxt = cnt_q + CNT_W'(1);

  // Next state and next values of the registered outputs.
  // The first bit is registered on the load edge, so it is on the line
  // one cycle after the load.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    last_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (din_valid_i) begin
          state_d      = ST_SHIFT;
          shift_d      = drop_head(din_i);
          cnt_d        = '0;
          sout_d       = head_bit(din_i);
          sout_valid_d = 1'b1;
          last_d       = (CNT_LAST == '0);
        end
      end

      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          // The last bit is on the line this cycle. The word is finished.
          shift_d = '0;
          cnt_d   = '0;
          if (HAS_GAP) begin
            state_d = ST_GAP;
            gap_d   = GAP_INIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          shift_d      = drop_head(shift_q);
          cnt_d        = cnt_nxt;
          sout_d       = head_bit(shift_q);
          sout_valid_d = 1'b1;
          last_d       = (cnt_nxt == CNT_LAST);
        end
      end

      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        shift_d = '0;
        cnt_d   = '0;
        gap_d   = '0;
      end
    endcase
  end

  // State, datapath and output registers, all cleared asynchronously.
  // A reset in the middle of a word drops the rest of that word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      last_q       <= last_d;
    end
  end

  assign din_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign sout_o       = sout_q;
  assign sout_valid_o = sout_valid_q;
  assign last_o       = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer. It drives three instances:
//   0: WIDTH=8, MSB first, one gap cycle
//   1: WIDTH=8, LSB first, one gap cycle
//   2: WIDTH=2, MSB first, no gap
// A cycle-level model predicts every output of every instance on each
// falling edge. Directed sequences add hand-computed expectations.
module tb_piso_serializer;

  localparam int MW [3] = '{8, 8, 2};
  localparam int MG [3] = '{1, 1, 0};
  localparam bit MM [3] = '{1'b1, 1'b0, 1'b1};

  logic        clk;
  logic        rst_n;
  logic [31:0] din_v [3];
  logic [2:0]  dv_v;
  logic [2:0]  rdy_v, sout_v, vld_v, last_v, busy_v;

  int n_err;
  int n_checks;

  // Model state: m_phase is the number of cycles since the load edge.
  logic [31:0] m_word  [3];
  int          m_phase [3];
  bit          m_act   [3];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din_v[0][7:0]), .din_valid_i(dv_v[0]),
    .din_ready_o(rdy_v[0]), .sout_o(sout_v[0]), .sout_valid_o(vld_v[0]),
    .last_o(last_v[0]), .busy_o(busy_v[0]));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din_v[1][7:0]), .din_valid_i(dv_v[1]),
    .din_ready_o(rdy_v[1]), .sout_o(sout_v[1]), .sout_valid_o(vld_v[1]),
    .last_o(last_v[1]), .busy_o(busy_v[1]));

  piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din_v[2][1:0]), .din_valid_i(dv_v[2]),
    .din_ready_o(rdy_v[2]), .sout_o(sout_v[2]), .sout_valid_o(vld_v[2]),
    .last_o(last_v[2]), .busy_o(busy_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input int idx, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %b expected %b", name, idx, $time, act, exp);
    end
  endtask

  // Model: a word is accepted when the model is idle and valid is high.
  // It then stays active for WIDTH + GAP cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_act[i]   = 1'b0;
        m_phase[i] = 0;
        m_word[i]  = '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!m_act[i]) begin
          if (dv_v[i]) begin
            m_word[i]  = din_v[i];
            m_phase[i] = 1;
            m_act[i]   = 1'b1;
          end
        end else begin
          m_phase[i] = m_phase[i] + 1;
          if (m_phase[i] > MW[i] + MG[i]) m_act[i] = 1'b0;
        end
      end
    end
  end

  // Compare every output of every instance against the model on each falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic e_v, e_b, e_l;
      int   bidx;
      e_v = m_act[i] && (m_phase[i] <= MW[i]);
      e_b = 1'b0;
      if (e_v) begin
        bidx = MM[i] ? (MW[i] - m_phase[i]) : (m_phase[i] - 1);
        e_b  = m_word[i][bidx];
      end
      e_l = e_v && (m_phase[i] == MW[i]);
      check1("model_sout",  i, sout_v[i], e_b);
      check1("model_valid", i, vld_v[i],  e_v);
      check1("model_last",  i, last_v[i], e_l);
      check1("model_busy",  i, busy_v[i], m_act[i]);
      check1("model_ready", i, rdy_v[i],  !m_act[i]);
    end
  end

  // Checks WIDTH consecutive bits of a word taken straight from the literal.
  task automatic expect_word(input string name, input int idx, input logic [31:0] word,
                             input int w, input bit msb);
    for (int j = 1; j <= w; j++) begin
      @(negedge clk);
      check1({name, "_bit"},   idx, sout_v[idx], msb ? word[w-j] : word[j-1]);
      check1({name, "_valid"}, idx, vld_v[idx],  1'b1);
      check1({name, "_last"},  idx, last_v[idx], (j == w));
    end
  endtask

  initial begin
    logic [8:0] s_exp, v_exp, l_exp;
    n_err    = 0;
    n_checks = 0;
    rst_n    = 1'b0;
    dv_v     = '0;
    for (int i = 0; i < 3; i++) din_v[i] = '0;

    // Outputs while in reset, before any clock edge.
    #3;
    check1("rst_sout",  0, sout_v[0], 1'b0);
    check1("rst_valid", 0, vld_v[0],  1'b0);
    check1("rst_last",  0, last_v[0], 1'b0);
    check1("rst_busy",  0, busy_v[0], 1'b0);
    check1("rst_ready", 0, rdy_v[0],  1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Load A5 on the first edge after reset is released: 1,0,1,0,0,1,0,1,
    // then one gap cycle, then ready again.
    din_v[0] = 32'hA5; dv_v[0] = 1'b1;
    @(posedge clk); #2 dv_v[0] = 1'b0;
    expect_word("a5", 0, 32'hA5, 8, 1'b1);
    @(negedge clk);
    check1("a5_gap_valid", 0, vld_v[0], 1'b0);
    check1("a5_gap_ready", 0, rdy_v[0], 1'b0);
    check1("a5_gap_busy",  0, busy_v[0], 1'b1);
    @(negedge clk);
    check1("a5_idle_ready", 0, rdy_v[0], 1'b1);

    // Valid held high, FF then 00: the two words are one gap cycle and
    // one idle cycle apart.
    din_v[0] = 32'hFF; dv_v[0] = 1'b1;
    @(posedge clk); #2 din_v[0] = 32'h00;
    expect_word("ff", 0, 32'hFF, 8, 1'b1);
    @(negedge clk);
    check1("ff_gap_valid",  0, vld_v[0], 1'b0);
    check1("ff_gap_ready",  0, rdy_v[0], 1'b0);
    @(negedge clk);
    check1("ff_idle_valid", 0, vld_v[0], 1'b0);
    check1("ff_idle_ready", 0, rdy_v[0], 1'b1);
    @(posedge clk); #2 dv_v[0] = 1'b0;
    expect_word("zero", 0, 32'h00, 8, 1'b1);
    repeat (3) @(negedge clk);

    // Changing din during the shift does not disturb the word being sent.
    din_v[0] = 32'h3C; dv_v[0] = 1'b1;
    @(posedge clk); #2 dv_v[0] = 1'b0; din_v[0] = 32'hC3;
    expect_word("3c", 0, 32'h3C, 8, 1'b1);
    repeat (3) @(negedge clk);

    // Asynchronous reset while the 4th bit of F0 is on the line.
    din_v[0] = 32'hF0; dv_v[0] = 1'b1;
    @(posedge clk); #2 dv_v[0] = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check1("f0_bit", 0, sout_v[0], 1'b1);
    end
    #1 rst_n = 1'b0;
    #1;
    check1("async_sout",  0, sout_v[0], 1'b0);
    check1("async_valid", 0, vld_v[0],  1'b0);
    check1("async_last",  0, last_v[0], 1'b0);
    check1("async_busy",  0, busy_v[0], 1'b0);
    check1("async_ready", 0, rdy_v[0],  1'b1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check1("abort_valid", 0, vld_v[0], 1'b0);
    check1("abort_busy",  0, busy_v[0], 1'b0);
    din_v[0] = 32'h81; dv_v[0] = 1'b1;
    @(posedge clk); #2 dv_v[0] = 1'b0;
    expect_word("81", 0, 32'h81, 8, 1'b1);
    repeat (3) @(negedge clk);

    // LSB first: 01 goes out as 1 followed by seven 0s.
    din_v[1] = 32'h01; dv_v[1] = 1'b1;
    @(posedge clk); #2 dv_v[1] = 1'b0;
    @(negedge clk);
    check1("lsb_first_bit", 1, sout_v[1], 1'b1);
    check1("lsb_first_last", 1, last_v[1], 1'b0);
    for (int j = 2; j <= 8; j++) begin
      @(negedge clk);
      check1("lsb_bit",  1, sout_v[1], 1'b0);
      check1("lsb_last", 1, last_v[1], (j == 8));
    end
    repeat (3) @(negedge clk);

    // WIDTH=2, no gap, valid held high with din=10: the pattern is 1,0,idle,
    // repeating.
    s_exp = 9'b100100100;
    v_exp = 9'b110110110;
    l_exp = 9'b010010010;
    din_v[2] = 32'h2; dv_v[2] = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      check1("w2_sout",  2, sout_v[2], s_exp[9-j]);
      check1("w2_valid", 2, vld_v[2],  v_exp[9-j]);
      check1("w2_last",  2, last_v[2], l_exp[9-j]);
      if (j == 8) dv_v[2] = 1'b0;
    end
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
- REQ-001: Parameter WIDTH, default 8, number of bits per parallel word (legal range 2..32).
- REQ-002: Parameter MSB_FIRST, default 1, shift order: 1 = bit WIDTH-1 first, 0 = bit 0 first.
- REQ-003: Parameter GAP_CYCLES, default 1, idle cycles inserted after each word (legal range 0..15).
- REQ-004: clk  input  1  sole clock; all state changes on rising edge.
- REQ-005: rst_n  input  1  asynchronous, active-low reset.
- REQ-006: din  input  WIDTH  parallel word to serialize.
- REQ-007: din_valid  input  1  din holds a word to load.
- REQ-008: din_ready  output  1  block can accept a word this cycle.
- REQ-009: sout  output  1  serial data bit, feeds the downstream shift register input.
- REQ-010: sout_valid  output  1  sout carries a data bit this cycle.
- REQ-011: last  output  1  sout carries the final bit of the current word.
- REQ-012: busy  output  1  block is in SHIFT or GAP.

Function
- REQ-013: FSM states: IDLE, SHIFT, GAP; all outputs driven from registers or decoded state only, no combinational path from din/din_valid to any output.
- REQ-014: IDLE: din_ready=1, busy=0, sout_valid=0, sout=0, last=0.
- REQ-015: Load occurs on the rising edge where din_valid=1 and din_ready=1; din captured into internal shift register, bit counter cleared, state -> SHIFT.
- REQ-016: din_valid while din_ready=0 is ignored; no word is queued or lost-flagged.
- REQ-017: Latency: first data bit appears on sout with sout_valid=1 in the cycle immediately after the load edge.
- REQ-018: SHIFT: exactly WIDTH consecutive cycles with sout_valid=1, one bit per cycle, order per MSB_FIRST; din_ready=0, busy=1.
- REQ-019: last=1 only in the WIDTH-th SHIFT cycle, 0 otherwise.
- REQ-020: Changes on din during SHIFT/GAP do not affect the serialized word.
- REQ-021: After the WIDTH-th bit: state -> GAP if GAP_CYCLES>0, else -> IDLE.
- REQ-022: GAP: GAP_CYCLES cycles with sout=0, sout_valid=0, last=0, din_ready=0, busy=1; then -> IDLE.
- REQ-023: Minimum spacing between successive load edges = WIDTH+GAP_CYCLES+1 cycles; din_valid held high continuously yields back-to-back words at that spacing.
- REQ-024: Bit counter width = clog2(WIDTH)+1 bits; gap counter 4 bits; neither wraps within a word.

Reset
- REQ-025: rst_n=0 forces immediately (no clock needed): state=IDLE, sout=0, sout_valid=0, last=0, busy=0, din_ready=1, shift and counter registers 0.
- REQ-026: Reset mid-word aborts the word; no remaining bits are emitted after rst_n returns high.
- REQ-027: First load possible on the first rising edge with rst_n=1.

Verification (WIDTH=8, GAP_CYCLES=1 unless stated)
- REQ-028: Reset, load 8'hA5 at edge k -> cycles k+1..k+8 sout=1,0,1,0,0,1,0,1, sout_valid=1, last=1 only at k+8; k+9 gap (sout_valid=0); din_ready=1 again from k+10.
- REQ-029: din_valid held high, din=8'hFF then 8'h00 -> second load at edge k+10; sout eight 1s, one invalid gap cycle, one idle cycle, eight 0s.
- REQ-030: Load 8'h3C, change din to 8'hC3 during SHIFT -> output remains 0,0,1,1,1,1,0,0.
- REQ-031: Load 8'hF0, drop rst_n asynchronously during 4th bit -> sout/sout_valid/busy 0 and din_ready 1 without clock edge; after release, load 8'h81 -> 1,0,0,0,0,0,0,1.
- REQ-032: MSB_FIRST=0, load 8'h01 -> first bit 1 then seven 0s; last on the eighth.
- REQ-033: WIDTH=2, GAP_CYCLES=0, din_valid held high, din=2'b10 -> sout 1,0, one idle cycle, 1,0 repeating; last every second valid bit.
